// File: rtl/uart_packet_rx.sv
// UART packet receiver: integrated bit sampler plus header/payload/checksum
// packet FSM with a valid/ready packet output and one-cycle error pulses.
module uart_packet_rx #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int DATA_BITS     = 12,
  parameter int ADDR_BITS     = 9,
  parameter int PAYLOAD_BYTES = 4,
  parameter int TIMEOUT_CLKS  = 16*CLKS_PER_BIT*(DATA_BITS+2)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx,
  output logic                       pkt_valid,
  input  logic                       pkt_ready,
  output logic                       pkt_rw,
  output logic                       pkt_mem_type,
  output logic [ADDR_BITS-1:0]       pkt_addr,
  output logic [8*PAYLOAD_BYTES-1:0] pkt_data,
  output logic                       err_valid,
  output logic [2:0]                 err_code
);

  localparam int CLK_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS+1);
  localparam int CNT_W = $clog2(PAYLOAD_BYTES+1);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS+1);

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_FRAME = 3'd1;
  localparam logic [2:0] E_HDR   = 3'd2;
  localparam logic [2:0] E_CHK   = 3'd3;
  localparam logic [2:0] E_TO    = 3'd4;
  localparam logic [2:0] E_OVR   = 3'd5;

  localparam logic [1:0] CMD_WR = 2'b11;
  localparam logic [1:0] CMD_RD = 2'b01;

  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (v == {TO_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Coincident errors resolve to the lowest code.
  function automatic logic [2:0] pick_err(input logic f, input logic h,
                                          input logic c, input logic t,
                                          input logic o);
    if (f) return E_FRAME;
    if (h) return E_HDR;
    if (c) return E_CHK;
    if (t) return E_TO;
    if (o) return E_OVR;
    return E_NONE;
  endfunction

  // ---- stage p0/p1: rx synchroniser
  logic rx_p0, rx_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  // ---- bit sampler
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} samp_t;
  samp_t s_state, s_next;

  logic [CLK_W-1:0]     clk_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 armed;
  logic                 half_hit, bit_hit, stop_hit;
  logic [DATA_BITS-1:0] shift_p1;

  assign half_hit = (clk_cnt == CLK_W'(CLKS_PER_BIT/2 - 1));
  assign bit_hit  = (clk_cnt == CLK_W'(CLKS_PER_BIT - 1));
  assign stop_hit = (s_state == S_STOP) && bit_hit;

  always_comb begin
    s_next = s_state;
    case (s_state)
      S_IDLE:  if (armed && !rx_p1) s_next = S_START;
      S_START: if (half_hit) s_next = rx_p1 ? S_IDLE : S_DATA;
      S_DATA:  if (bit_hit && (bit_cnt == BIT_W'(DATA_BITS-1))) s_next = S_STOP;
      S_STOP:  if (bit_hit) s_next = S_IDLE;
      default: s_next = S_IDLE;
    endcase
  end

  // ---- stage p2: sampled word with its valid (word_done) and framing flag
  logic                 vld_p2, ferr_p2;
  logic [DATA_BITS-1:0] word_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_state <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      armed   <= 1'b1;
      vld_p2  <= 1'b0;
      ferr_p2 <= 1'b0;
    end else begin
      s_state <= s_next;
      clk_cnt <= ((s_state == S_IDLE) || (s_state != s_next) || bit_hit) ? '0 : clk_cnt + 1'b1;
      if (s_state != S_DATA)
        bit_cnt <= '0;
      else if (bit_hit)
        bit_cnt <= bit_cnt + 1'b1;
      // After a bad stop bit the line must return high before a new start counts.
      if (stop_hit && !rx_p1)
        armed <= 1'b0;
      else if (rx_p1)
        armed <= 1'b1;
      vld_p2  <= stop_hit && rx_p1;
      ferr_p2 <= stop_hit && !rx_p1;
    end
  end

  always_ff @(posedge clk) begin
    if ((s_state == S_DATA) && bit_hit)
      shift_p1 <= {rx_p1, shift_p1[DATA_BITS-1:1]};
    if (stop_hit)
      word_p2 <= shift_p1;
  end

  // ---- packet FSM
  typedef enum logic [1:0] {P_WAIT_HDR, P_PAYLOAD, P_CHECK, P_HOLD} pkt_t;
  pkt_t p_state, p_next, dec_state;

  logic [CNT_W-1:0]         byte_cnt;
  logic [TO_W-1:0]          idle_cnt;
  logic                     drop;
  logic [7:0]               csum;
  logic                     hdr_rw, hdr_mem;
  logic [ADDR_BITS-1:0]     hdr_addr;
  logic [8*PAYLOAD_BYTES-1:0] payload;

  logic [1:0] hdr_cmd;
  logic       dec_ok, take, handshake, to_hit;
  logic       load_hdr, load_byte, load_pkt;
  logic       e_hdr, e_chk, e_to, e_ovr;

  assign hdr_cmd   = word_p2[DATA_BITS-1 -: 2];
  assign dec_ok    = (hdr_cmd == CMD_WR) || (hdr_cmd == CMD_RD);
  assign dec_state = (hdr_cmd == CMD_WR) ? P_PAYLOAD : P_CHECK;
  assign take      = vld_p2 && !drop;
  assign handshake = pkt_valid && pkt_ready;
  assign to_hit    = !vld_p2 && (idle_cnt == TO_W'(TIMEOUT_CLKS-1));

  always_comb begin
    p_next    = p_state;
    load_hdr  = 1'b0;
    load_byte = 1'b0;
    load_pkt  = 1'b0;
    e_hdr     = 1'b0;
    e_chk     = 1'b0;
    e_to      = 1'b0;
    e_ovr     = 1'b0;
    case (p_state)
      P_WAIT_HDR: begin
        if (take) begin
          if (dec_ok) begin
            p_next   = dec_state;
            load_hdr = 1'b1;
          end else begin
            e_hdr = 1'b1;
          end
        end
      end
      P_PAYLOAD: begin
        if (take) begin
          load_byte = 1'b1;
          if (byte_cnt == CNT_W'(PAYLOAD_BYTES-1)) p_next = P_CHECK;
        end else if (to_hit) begin
          e_to   = 1'b1;
          p_next = P_WAIT_HDR;
        end
      end
      P_CHECK: begin
        if (take) begin
          if (word_p2[7:0] == csum) begin
            load_pkt = 1'b1;
            p_next   = P_HOLD;
          end else begin
            e_chk  = 1'b1;
            p_next = P_WAIT_HDR;
          end
        end else if (to_hit) begin
          e_to   = 1'b1;
          p_next = P_WAIT_HDR;
        end
      end
      P_HOLD: begin
        // A word landing on the handshake cycle is the next header, not an overrun.
        if (handshake) begin
          p_next = P_WAIT_HDR;
          if (take) begin
            if (dec_ok) begin
              p_next   = dec_state;
              load_hdr = 1'b1;
            end else begin
              e_hdr = 1'b1;
            end
          end
        end else if (take) begin
          e_ovr = 1'b1;
        end
      end
      default: p_next = P_WAIT_HDR;
    endcase
    if (ferr_p2 && (p_state != P_HOLD))
      p_next = P_WAIT_HDR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_state      <= P_WAIT_HDR;
      byte_cnt     <= '0;
      idle_cnt     <= '0;
      drop         <= 1'b0;
      pkt_valid    <= 1'b0;
      pkt_rw       <= 1'b0;
      pkt_mem_type <= 1'b0;
      pkt_addr     <= '0;
      pkt_data     <= '0;
      err_valid    <= 1'b0;
      err_code     <= E_NONE;
    end else begin
      p_state  <= p_next;
      idle_cnt <= vld_p2 ? '0 : sat_inc(idle_cnt);
      if (load_hdr)
        byte_cnt <= '0;
      else if (load_byte)
        byte_cnt <= byte_cnt + 1'b1;
      // An overrun drops the rest of that packet; a quiet gap marks its end.
      if (e_ovr)
        drop <= 1'b1;
      else if (to_hit)
        drop <= 1'b0;
      if (load_pkt) begin
        pkt_valid    <= 1'b1;
        pkt_rw       <= hdr_rw;
        pkt_mem_type <= hdr_mem;
        pkt_addr     <= hdr_addr;
        pkt_data     <= hdr_rw ? payload : '0;
      end else if (handshake) begin
        pkt_valid <= 1'b0;
      end
      err_valid <= ferr_p2 | e_hdr | e_chk | e_to | e_ovr;
      err_code  <= pick_err(ferr_p2, e_hdr, e_chk, e_to, e_ovr);
    end
  end

  always_ff @(posedge clk) begin
    if (load_hdr) begin
      hdr_rw   <= (hdr_cmd == CMD_WR);
      hdr_mem  <= word_p2[DATA_BITS-3];
      hdr_addr <= word_p2[ADDR_BITS-1:0];
      csum     <= word_p2[7:0];
    end else if (load_byte) begin
      csum <= csum ^ word_p2[7:0];
    end
    // First payload byte lands in the most significant slot.
    if (load_byte) begin
      for (int i = 0; i < PAYLOAD_BYTES; i++) begin
        if (byte_cnt == CNT_W'(PAYLOAD_BYTES-1-i))
          payload[i*8 +: 8] <= word_p2[7:0];
      end
    end
  end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Directed bench for uart_packet_rx: expected packets and error codes are
// queued as stimulus is sent and checked as the DUT produces them.
`timescale 1ns/1ps
module tb_uart_packet_rx;
  localparam int CPB = 4;
  localparam int DB  = 12;
  localparam int TO  = 16*CPB*(DB+2);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        pkt_ready = 1'b1;
  logic        pkt_valid, pkt_rw, pkt_mem_type, err_valid;
  logic [8:0]  pkt_addr;
  logic [31:0] pkt_data;
  logic [2:0]  err_code;

  uart_packet_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_rw(pkt_rw), .pkt_mem_type(pkt_mem_type),
    .pkt_addr(pkt_addr), .pkt_data(pkt_data),
    .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic        mem;
    logic [8:0]  addr;
    logic [31:0] data;
  } exp_pkt_t;

  exp_pkt_t   exp_pkt[$];
  logic [2:0] exp_err[$];
  exp_pkt_t   mon_e;
  logic       prev_valid;
  int n_checks = 0;
  int n_fail   = 0;
  int pkt_seen = 0;
  int err_seen = 0;
  int saved_pkt, saved_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input logic rw, input logic mem, input logic [8:0] addr,
                          input logic [31:0] data);
    exp_pkt_t e;
    e.rw = rw; e.mem = mem; e.addr = addr; e.data = data;
    exp_pkt.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [11:0] w, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = w[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_wr(input logic [11:0] h, input logic [11:0] b0, input logic [11:0] b1,
                         input logic [11:0] b2, input logic [11:0] b3, input logic [11:0] cs);
    send_word(h, 1'b1);
    send_word(b0, 1'b1);
    send_word(b1, 1'b1);
    send_word(b2, 1'b1);
    send_word(b3, 1'b1);
    send_word(cs, 1'b1);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_pkt_valid"},    64'(pkt_valid),    64'd0);
    check({pfx, "_pkt_rw"},       64'(pkt_rw),       64'd0);
    check({pfx, "_pkt_mem_type"}, 64'(pkt_mem_type), 64'd0);
    check({pfx, "_pkt_addr"},     64'(pkt_addr),     64'd0);
    check({pfx, "_pkt_data"},     64'(pkt_data),     64'd0);
    check({pfx, "_err_valid"},    64'(err_valid),    64'd0);
    check({pfx, "_err_code"},     64'(err_code),     64'd0);
  endtask

  // Output monitor: compares each new packet and each error pulse to the scoreboard.
  initial begin
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (pkt_valid && !prev_valid) begin
          pkt_seen++;
          if (exp_pkt.size() == 0) begin
            check("pkt_unexpected", 64'(pkt_valid), 64'd0);
          end else begin
            mon_e = exp_pkt.pop_front();
            check("pkt_rw",   64'(pkt_rw),       64'(mon_e.rw));
            check("pkt_mem",  64'(pkt_mem_type), 64'(mon_e.mem));
            check("pkt_addr", 64'(pkt_addr),     64'(mon_e.addr));
            check("pkt_data", 64'(pkt_data),     64'(mon_e.data));
          end
        end
        if (err_valid) begin
          err_seen++;
          if (exp_err.size() == 0)
            check("err_unexpected", 64'(err_valid), 64'd0);
          else
            check("err_code", 64'(err_code), 64'(exp_err.pop_front()));
        end
        prev_valid = pkt_valid;
      end
    end
  end

  initial begin
    idle(4);
    check_zero("reset");
    reset = 1'b0;
    idle(10);

    push_pkt(1'b1, 1'b0, 9'h005, 32'h12345678);
    send_wr(12'hC05, 12'h012, 12'h034, 12'h056, 12'h078, 12'h00D);
    idle(20);

    push_pkt(1'b0, 1'b1, 9'h0A3, 32'h0);
    send_word(12'h6A3, 1'b1);
    send_word(12'h0A3, 1'b1);
    idle(20);

    exp_err.push_back(3'd3);
    send_wr(12'hC05, 12'h012, 12'h034, 12'h056, 12'h078, 12'h00E);
    idle(20);
    push_pkt(1'b1, 1'b1, 9'h010, 32'hAABBCCDD);
    send_wr(12'hE10, 12'h0AA, 12'h0BB, 12'h0CC, 12'h0DD, 12'h010);
    idle(20);

    exp_err.push_back(3'd2);
    send_word(12'h805, 1'b1);
    idle(20);

    exp_err.push_back(3'd1);
    send_word(12'hC05, 1'b1);
    send_word(12'h012, 1'b1);
    send_word(12'h034, 1'b0);
    idle(20);

    exp_err.push_back(3'd4);
    send_word(12'hC05, 1'b1);
    idle(TO + 50);

    pkt_ready = 1'b0;
    push_pkt(1'b1, 1'b0, 9'h005, 32'h12345678);
    send_wr(12'hC05, 12'h012, 12'h034, 12'h056, 12'h078, 12'h00D);
    idle(20);
    check("hold_valid", 64'(pkt_valid), 64'd1);
    exp_err.push_back(3'd5);
    send_wr(12'hE10, 12'h0AA, 12'h0BB, 12'h0CC, 12'h0DD, 12'h010);
    idle(20);
    check("hold_valid_kept", 64'(pkt_valid), 64'd1);
    check("hold_addr_kept",  64'(pkt_addr),  64'h005);
    check("hold_data_kept",  64'(pkt_data),  64'h12345678);
    pkt_ready = 1'b1;
    @(posedge clk);
    #1;
    check("valid_drop", 64'(pkt_valid), 64'd0);
    idle(TO + 50);

    saved_pkt = pkt_seen;
    saved_err = err_seen;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    idle(60);
    check("glitch_no_pkt", 64'(pkt_seen), 64'(saved_pkt));
    check("glitch_no_err", 64'(err_seen), 64'(saved_err));

    send_word(12'hC05, 1'b1);
    send_word(12'h012, 1'b1);
    rx = 1'b0;
    idle(10);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    idle(2);
    reset = 1'b0;
    idle(10);
    push_pkt(1'b1, 1'b1, 9'h010, 32'hAABBCCDD);
    send_wr(12'hE10, 12'h0AA, 12'h0BB, 12'h0CC, 12'h0DD, 12'h010);
    idle(20);

    check("pkt_queue_empty", 64'(exp_pkt.size()), 64'd0);
    check("err_queue_empty", 64'(exp_err.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
